// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: instruction/data memory handshake between the sequencer and the memories
interface multicycle_control_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath enables; MCYC_CTRL_PERF_EN adds retire/stall counters
module multicycle_control_fsm (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop_req,
  input  logic [3:0]            opcode,
  input  logic                  branch_taken,
  multicycle_control_fsm_if.master mem,
  output logic                  ir_we,
  output logic                  alu_en,
  output logic [3:0]            alu_operation_type,
  output logic [3:0]            branch_operation_type,
  output logic                  rf_we,
  output logic                  rf_wdata_sel,
  output logic                  pc_we,
  output logic [1:0]            pc_src,
  output logic                  instr_done,
  output logic                  busy,
  output logic                  panic
`ifdef MCYC_CTRL_PERF_EN
  ,
  output logic [31:0]           retired_count,
  output logic [31:0]           stall_count
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t     state;
  state_t     bound;
  logic [3:0] op_q;
  logic       op_br;
  assign bound = stop_req ? IDLE : FETCH;
  assign op_br = op_q inside {[4'd3:4'd5]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      op_q  <= 4'd0;
      panic <= 1'b0;
    end else
      case (state)
        IDLE:    state <= start ? FETCH : IDLE;
        FETCH:   state <= mem.imem_ready ? DECODE : FETCH;
        DECODE: begin
          op_q  <= opcode;
          panic <= panic | (opcode >= 4'd11);
          state <= opcode >= 4'd11 ? HALT : opcode >= 4'd7 ? bound : EXEC;
        end
        EXEC:    state <= op_q == 4'd0 ? WB : op_q inside {4'd1, 4'd2} ? MEM : bound;
        MEM:     state <= !mem.dmem_ready ? MEM : op_q == 4'd1 ? WB : bound;
        WB:      state <= bound;
        default: state <= HALT;
      endcase
  // Moore decode, except fetch and store completion which must follow ready in the same cycle
  assign mem.imem_req          = state == FETCH;
  assign ir_we                 = mem.imem_req & mem.imem_ready;
  assign mem.dmem_req          = state == MEM;
  assign mem.dmem_we           = mem.dmem_req & (op_q == 4'd2);
  assign alu_en                = state == EXEC;
  assign alu_operation_type    = alu_en && op_q == 4'd0 ? 4'd1 : 4'd0;
  assign branch_operation_type = alu_en && op_br ? op_q - 4'd2 : 4'd0;
  assign rf_we                 = state == WB;
  assign rf_wdata_sel          = rf_we & (op_q == 4'd1);
  assign pc_we                 = (state == DECODE && opcode inside {[4'd7:4'd10]}) ||
                                 (alu_en && op_q inside {[4'd3:4'd6]}) ||
                                 (mem.dmem_we && mem.dmem_ready) || rf_we;
  assign pc_src                = alu_en && op_q == 4'd6 ? 2'b10 : alu_en && op_br && branch_taken ? 2'b01 : 2'b00;
  assign instr_done            = pc_we;
  assign busy                  = state != IDLE && state != HALT;
`ifdef MCYC_CTRL_PERF_EN
  logic stall;
  assign stall = (mem.imem_req & ~mem.imem_ready) | (mem.dmem_req & ~mem.dmem_ready);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      retired_count <= 32'd0;
      stall_count   <= 32'd0;
    end else if (busy) begin
      retired_count <= retired_count + {31'd0, instr_done};
      stall_count   <= stall_count + {31'd0, stall};
    end
`endif
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the processor datapath. It fetches each instruction over a ready/request memory handshake and decodes the 4-bit opcode. It then steps the shared ALU, data memory, register file and PC through FETCH/DECODE/EXEC/MEM/WB states, which replaces the single-cycle decoder's purely combinational strobes with per-state enables. It sits between the instruction/data memory ports and the datapath register-enable inputs.

## Interface
- No parameters. Opcode width is fixed at 4, and ALU and branch type codes are fixed at 4.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution from IDLE; ignored in every other state
- stop_req  in  1  return to IDLE at the next instruction boundary
- opcode  in  4  instruction-register opcode field; sampled only in DECODE
- imem_ready  in  1  instruction memory has data; honoured only while imem_req=1
- dmem_ready  in  1  data access complete; honoured only while dmem_req=1
- branch_taken  in  1  comparator result from the datapath; valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load the instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write (store)
- alu_en  out  1  ALU operand/result register enable
- alu_operation_type  out  4  0001=ADD; 0000 otherwise
- branch_operation_type  out  4  0001=BE, 0010=BGT, 0011=BGE; 0000 otherwise
- rf_we  out  1  register-file write
- rf_wdata_sel  out  1  0=ALU result, 1=memory data
- pc_we  out  1  PC update
- pc_src  out  2  00=PC+1, 01=branch target, 10=jump target
- instr_done  out  1  one-cycle retire pulse; equal to pc_we
- busy  out  1  state is neither IDLE nor HALT
- panic  out  1  sticky illegal-opcode flag

## Operation
- The controller has seven states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is 3-bit binary in that order (IDLE=0).
- The opcode is latched into an internal op_q register in DECODE. All later states decode op_q.
- Opcode classes: 0=ALU, 1=LW, 2=SW, 3/4/5=BE/BGT/BGE, 6=JUMP, 7–10=NOP, 11–15=illegal.
- IDLE: start=1 moves to FETCH.
- FETCH:
  - imem_req=1.
  - When imem_ready=1, ir_we=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Illegal opcode: set panic=1, go to HALT, and do not update the PC.
  - NOP: pc_we=1, pc_src=00, then go to the boundary step.
  - All other opcodes: go to EXEC.
- EXEC: alu_en=1 and type outputs driven from op_q.
  - ALU opcode goes to WB.
  - LW or SW goes to MEM; the ALU computes the address.
  - Branch: pc_we=1, pc_src = branch_taken ? 01 : 00, then the boundary step.
  - JUMP: pc_we=1, pc_src=10, then the boundary step.
- MEM:
  - dmem_req=1, and dmem_we=1 iff op_q=2. Both are held until dmem_ready.
  - On dmem_ready: LW goes to WB; SW asserts pc_we=1 with pc_src=00, then the boundary step.
- WB:
  - rf_we=1.
  - rf_wdata_sel=1 iff op_q=1.
  - pc_we=1, pc_src=00, then the boundary step.
- Boundary step: go to IDLE if stop_req=1 in that cycle, otherwise go to FETCH.
- HALT: absorbing. start and stop_req are ignored; only reset exits.
- Every output not listed for a state is 0.
- All outputs decode from the state (Moore). The exceptions are ir_we and MEM-exit pc_we, which also gate on ready.

## Timing
- Reset (asynchronous, immediate): state=IDLE, op_q=0, panic=0, and every output is 0. This also applies mid-instruction; an in-flight memory request is dropped.
- Cycles per instruction with zero-wait memory (ready high in the first request cycle):
  - NOP: 2
  - Branch or JUMP: 3
  - ALU or SW: 4
  - LW: 5
- Each ready-low cycle adds one cycle.
- From IDLE, start at edge N puts the controller in FETCH at N+1, with imem_req=1 in that cycle.
- When stop_req and a retire occur together, the retire completes and the controller goes to IDLE. stop_req in any other cycle is ignored, so it must be held until a boundary.
- start and stop_req both high in IDLE: start wins.
- A ready pulse without its matching request has no effect.

## Configuration
- MCYC_CTRL_PERF_EN: when defined, the block adds two outputs.
  - retired_count [31:0] counts instr_done pulses.
  - stall_count [31:0] counts cycles with (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready).
  - Both reset to 0, wrap from 2^32−1 to 0, and hold in IDLE and HALT.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset, start, then ADD (opcode 0) with zero-wait memory: imem_req, DECODE, alu_en with alu_operation_type=0001, then rf_we=1 with rf_wdata_sel=0, pc_we=1, pc_src=00, instr_done=1. The instruction takes 4 cycles.
- LW (1) with dmem_ready delayed 3 cycles: dmem_req held for 4 cycles with dmem_we=0, then WB with rf_wdata_sel=1. The instruction takes 8 cycles; with PERF enabled, stall_count=3.
- BGT (4) with branch_taken=1, then BE (3) with branch_taken=0: branch_operation_type is 0010 then 0001, and pc_src is 01 then 00. Each instruction takes 3 cycles.
- Opcode 12 in DECODE: panic=1 and HALT with no pc_we. A later start=1 has no effect, and reset_n=0 clears panic.
- stop_req asserted mid-SW (2): the SW completes with dmem_we=1 and pc_we=1, and the next state is IDLE with busy=0.
- reset_n low while in MEM with dmem_req=1: all outputs are 0 immediately without waiting for a clock edge; after release and start, execution resumes from FETCH.
